ctrl_prog_mem: RTL and testbench
================================

Name: ctrl_prog_mem

Overview:
- Program memory and loader directly upstream of the controller's instruction fetch.
- In programming mode, assembles allocation-instruction words from a byte-serial valid/ready load stream and writes them sequentially.
- In run mode, answers the controller's `fetch`/`pc` request with a registered `instr_word`, one cycle later.
- Replaces the behavioural ROM plus `$readmemb` path, so the full design can be programmed in-system.

Parameters:
- VEC_ID_WIDTH, 3, vector id field width
- REGFILE_ADDR_WIDTH, 4, register-file address field width
- DATA_ADDR_WIDTH, 6, data/coef address field width
- INSTR_ADDR_WIDTH, 5, pc width; PROG_SIZE = 2**INSTR_ADDR_WIDTH words
- LOAD_WIDTH, 8, load bus width
- Derived localparam INSTR_WIDTH = 2 + VEC_ID_WIDTH + 2*REGFILE_ADDR_WIDTH + 3*DATA_ADDR_WIDTH (31 at defaults).
- Derived localparam BEATS = ceil(INSTR_WIDTH/LOAD_WIDTH) (4 at defaults).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- prog  in  1  programming-mode request, level
- ld_data  in  LOAD_WIDTH  load beat
- ld_valid  in  1  load beat valid
- ld_ready  out  1  load beat accepted when ld_valid & ld_ready
- fetch  in  1  controller fetch request
- pc  in  INSTR_ADDR_WIDTH  fetch address
- instr_word  out  INSTR_WIDTH  registered instruction
- instr_valid  out  1  one-cycle pulse, instr_word updated this cycle
- prog_len  out  INSTR_ADDR_WIDTH+1  number of words loaded
- running  out  1  high in RUN state
- load_err  out  1  sticky: partial word discarded or parity failure
- pc_oob  out  1  sticky: fetch with pc >= prog_len

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state IDLE, ld_ready 0, instr_word 0, instr_valid 0, prog_len 0, running 0, load_err 0, pc_oob 0, write pointer 0, beat counter 0. Memory contents are not reset.
- IDLE:
  - prog=1 → LOAD; clear write pointer, beat counter, load_err.
  - Fetch is ignored.
- LOAD:
  - ld_ready = 1 while write pointer < PROG_SIZE.
  - Each handshake places the beat little-endian: beat k fills bits [k*LOAD_WIDTH +: LOAD_WIDTH]; bits above INSTR_WIDTH in the last beat are dropped.
  - On the BEATS-th beat: the word is written at the write pointer the same edge, the pointer increments, and the beat counter returns to 0.
  - Full (pointer == PROG_SIZE): ld_ready 0; no further writes, no error.
  - prog=0: prog_len <= write pointer. If the beat counter is nonzero, the partial word is discarded and load_err is set. Next state is RUN if the pointer > 0, else IDLE.
  - Fetch in LOAD is ignored; instr_word holds.
- RUN:
  - running=1.
  - fetch=1 with pc < prog_len: instr_word <= mem[pc] at the next edge, instr_valid pulses 1 cycle.
  - fetch=1 with pc >= prog_len: instr_word <= 0, instr_valid pulses, pc_oob set.
  - Back-to-back fetches give one word per cycle.
  - prog=1 → LOAD, clearing pc_oob. prog has priority over a simultaneous fetch.
- Reset mid-load: the pointer resets to 0 and prog_len to 0; already-written memory words become unreachable.
- Read and write never occur in the same cycle (they are state-exclusive), so single-port memory inference is allowed.

Optional Feature:
- Macro: CTRL_PROG_PARITY_EN.
- Defined:
  - Each word takes BEATS+1 beats; the extra final beat carries even parity of the assembled word in bit 0.
  - On mismatch the word is not written, the pointer does not advance, and load_err is set.
- Undefined:
  - BEATS beats per word, no parity check; load_err arises only from partial words.

Decomposition:
- Shared package/header: INSTR_WIDTH and BEATS derivations, instruction field offsets (lstg_f, upse_f, vector_id, result_reg, error_reg, data_uptr, data_lptr, coef_ptr), and state encodings IDLE/LOAD/RUN.
- One natural sub-module, ctrl_prog_asm: beat counter plus word assembler (and parity check when enabled), emitting a word_valid/word pulse to the memory wrapper.

Test Plan:
- Reset, prog=1, load 4 words of 4 beats each (word0 = 31'h12345678 & mask), prog=0 → prog_len=4, running=1, load_err=0.
- RUN with fetch=1, pc=2 → next cycle instr_word = word2, instr_valid=1; fetch held over pc 0..3 → one word per cycle in order.
- Fetch pc=7 with prog_len=4 → instr_word=0, pc_oob=1, sticky until next prog=1.
- Load 2 full words plus 2 beats, then prog=0 → prog_len=2, load_err=1.
- Load 33 words → ld_ready drops after 32, prog_len=32, mem[0] unchanged by the extra beats. With CTRL_PROG_PARITY_EN, a bad parity beat on word 1 → prog_len=1, load_err=1.
- rst asserted mid-load after 3 beats → all outputs at reset values next cycle; a fresh 1-word load yields prog_len=1.

Source files
------------

// File: rtl/ctrl_prog_pkg.sv
// ctrl_prog_pkg: instruction width/beat derivations, instruction field offsets and loader states
package ctrl_prog_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  function automatic int instr_width(int v, int r, int d);
    return 2 + v + 2 * r + 3 * d;
  endfunction
  function automatic int beats_for(int iw, int lw);
    return (iw + lw - 1) / lw;
  endfunction
  localparam int INSTR_WIDTH = instr_width(3, 4, 6);
  localparam int BEATS = beats_for(INSTR_WIDTH, 8);
  localparam int COEF_PTR_LSB = 0;
  localparam int DATA_LPTR_LSB = 6;
  localparam int DATA_UPTR_LSB = 12;
  localparam int ERROR_REG_LSB = 18;
  localparam int RESULT_REG_LSB = 22;
  localparam int VECTOR_ID_LSB = 26;
  localparam int UPSE_F_LSB = 29;
  localparam int LSTG_F_LSB = 30;
endpackage

// File: rtl/ctrl_prog_asm.sv
// ctrl_prog_asm: beat counter and little-endian word assembler, extra parity beat under CTRL_PROG_PARITY_EN
module ctrl_prog_asm
  import ctrl_prog_pkg::*;
#(
  parameter int IW = 31,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          beat,
  input  logic [LW-1:0] data,
  output logic          word_valid,
  output logic [IW-1:0] word,
  output logic          par_err,
  output logic          partial
);
  localparam int BEATS = beats_for(IW, LW);
`ifdef CTRL_PROG_PARITY_EN
  localparam int NB = BEATS + 1;
`else
  localparam int NB = BEATS;
`endif
  localparam int CW = $clog2(NB + 1);
  logic [CW-1:0] cnt;
  logic [BEATS*LW-1:0] acc, nxt;
  logic last;
  assign last = cnt == CW'(NB - 1);
  assign partial = cnt != '0;
  always_comb begin
    nxt = acc;
    if (int'(cnt) < BEATS) nxt[int'(cnt)*LW +: LW] = data;
  end
`ifdef CTRL_PROG_PARITY_EN
  logic par_ok;
  assign par_ok = (^acc[IW-1:0]) == data[0];
  assign word = acc[IW-1:0];
  assign word_valid = beat && last && par_ok;
  assign par_err = beat && last && !par_ok;
`else
  assign word = nxt[IW-1:0];
  assign word_valid = beat && last;
  assign par_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (beat) cnt <= last ? '0 : cnt + 1'b1;
    if (beat) acc <= nxt;
  end
endmodule

// File: rtl/ctrl_prog_mem.sv
// ctrl_prog_mem: in-system loadable program memory feeding instruction fetch (CTRL_PROG_PARITY_EN adds a parity beat per word)
module ctrl_prog_mem
  import ctrl_prog_pkg::*;
#(
  parameter int VEC_ID_WIDTH = 3,
  parameter int REGFILE_ADDR_WIDTH = 4,
  parameter int DATA_ADDR_WIDTH = 6,
  parameter int INSTR_ADDR_WIDTH = 5,
  parameter int LOAD_WIDTH = 8,
  localparam int INSTR_WIDTH = instr_width(VEC_ID_WIDTH, REGFILE_ADDR_WIDTH, DATA_ADDR_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        prog,
  input  logic [LOAD_WIDTH-1:0]       ld_data,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic                        fetch,
  input  logic [INSTR_ADDR_WIDTH-1:0] pc,
  output logic [INSTR_WIDTH-1:0]      instr_word,
  output logic                        instr_valid,
  output logic [INSTR_ADDR_WIDTH:0]   prog_len,
  output logic                        running,
  output logic                        load_err,
  output logic                        pc_oob
);
  localparam int AW = INSTR_ADDR_WIDTH;
  localparam int PROG_SIZE = 2 ** AW;
  state_t state, state_nxt;
  logic [AW:0] wp;
  logic [INSTR_WIDTH-1:0] mem [PROG_SIZE];
  logic [INSTR_WIDTH-1:0] word;
  logic beat, word_valid, par_err, partial, enter, leave, rd, oob;
  assign ld_ready = state == LOAD && prog && !wp[AW];
  assign beat = ld_valid && ld_ready;
  assign running = state == RUN;
  assign enter = state != LOAD && prog;
  assign leave = state == LOAD && !prog;
  assign rd = running && !prog && fetch;
  assign oob = {1'b0, pc} >= prog_len;
  always_comb begin
    state_nxt = state;
    state_nxt = enter ? LOAD : leave ? (wp != '0 ? RUN : IDLE) : state;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  ctrl_prog_asm #(.IW(INSTR_WIDTH), .LW(LOAD_WIDTH)) u_asm (
    .clk(clk),
    .rst(rst),
    .clr(state != LOAD || !prog),
    .beat(beat),
    .data(ld_data),
    .word_valid(word_valid),
    .word(word),
    .par_err(par_err),
    .partial(partial)
  );
  always_ff @(posedge clk) if (word_valid) mem[wp[AW-1:0]] <= word;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      prog_len <= '0;
      instr_word <= '0;
      instr_valid <= 1'b0;
      load_err <= 1'b0;
      pc_oob <= 1'b0;
    end else begin
      instr_valid <= rd;
      if (enter) begin
        wp <= '0;
        load_err <= 1'b0;
        pc_oob <= 1'b0;
      end
      if (word_valid) wp <= wp + 1'b1;
      if (par_err || (leave && partial)) load_err <= 1'b1;
      if (leave) prog_len <= wp;
      if (rd) begin
        instr_word <= oob ? '0 : mem[pc];
        if (oob) pc_oob <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ctrl_prog_mem.sv
// tb_ctrl_prog_mem: randomized self-checking bench against a queue-based loader model
module tb_ctrl_prog_mem;
  localparam int IW = 2 + 3 + 2 * 4 + 3 * 6;
  localparam int LW = 8;
  localparam int NBT = (IW + LW - 1) / LW;
  localparam int SIZE = 32;
`ifdef CTRL_PROG_PARITY_EN
  localparam int NBW = NBT + 1;
`else
  localparam int NBW = NBT;
`endif
  typedef enum int {M_IDLE, M_LOAD, M_RUN} mode_t;
  logic clk = 0, rst = 1, prog = 0, ld_valid = 0, fetch = 0;
  logic [LW-1:0] ld_data = '0;
  logic [4:0] pc = '0;
  logic ld_ready, instr_valid, running, load_err, pc_oob;
  logic [IW-1:0] instr_word;
  logic [5:0] prog_len;
  int vectors = 0, miscompares = 0;
  bit chk = 0;
  mode_t mode = M_IDLE;
  logic [IW-1:0] m_mem [SIZE];
  logic [LW-1:0] m_beats [$];
  int m_wp = 0, m_len = 0;
  bit m_err = 0, m_oob = 0, m_valid = 0;
  logic [IW-1:0] m_word = '0;
  ctrl_prog_mem dut (
    .clk(clk),
    .rst(rst),
    .prog(prog),
    .ld_data(ld_data),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .fetch(fetch),
    .pc(pc),
    .instr_word(instr_word),
    .instr_valid(instr_valid),
    .prog_len(prog_len),
    .running(running),
    .load_err(load_err),
    .pc_oob(pc_oob)
  );
  always #5 clk = ~clk;
  task automatic check(string n, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic model_edge();
    logic [63:0] w;
    bit ok;
    m_valid = 0;
    if (rst) begin
      mode = M_IDLE;
      m_wp = 0;
      m_len = 0;
      m_err = 0;
      m_oob = 0;
      m_word = '0;
      m_beats.delete();
    end else if (mode != M_LOAD && prog) begin
      mode = M_LOAD;
      m_wp = 0;
      m_err = 0;
      m_oob = 0;
    end else if (mode == M_LOAD && !prog) begin
      m_len = m_wp;
      if (m_beats.size() != 0) m_err = 1;
      m_beats.delete();
      mode = m_wp > 0 ? M_RUN : M_IDLE;
    end else if (mode == M_LOAD && ld_valid && m_wp < SIZE) begin
      m_beats.push_back(ld_data);
      if (m_beats.size() == NBW) begin
        w = 0;
        for (int i = 0; i < NBT; i++) w = w | (64'(m_beats[i]) << (LW * i));
        ok = 1;
`ifdef CTRL_PROG_PARITY_EN
        ok = m_beats[NBT][0] == ^w[IW-1:0];
`endif
        if (ok) begin
          m_mem[m_wp] = w[IW-1:0];
          m_wp++;
        end else m_err = 1;
        m_beats.delete();
      end
    end else if (mode == M_RUN && fetch) begin
      m_valid = 1;
      if (int'(pc) < m_len) m_word = m_mem[pc];
      else begin
        m_word = '0;
        m_oob = 1;
      end
    end
  endtask
  always @(negedge clk) if (chk) begin
    check("instr_word", 64'(instr_word), 64'(m_word));
    check("instr_valid", 64'(instr_valid), 64'(m_valid));
    check("prog_len", 64'(prog_len), 64'(m_len));
    check("running", 64'(running), 64'(mode == M_RUN));
    check("load_err", 64'(load_err), 64'(m_err));
    check("pc_oob", 64'(pc_oob), 64'(m_oob));
    if (!(mode == M_LOAD && !prog)) check("ld_ready", 64'(ld_ready), 64'(mode == M_LOAD && prog && m_wp < SIZE));
  end
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic beat(logic [LW-1:0] b);
    while ($urandom_range(3) == 0) begin
      fetch = 1'($urandom);
      pc = 5'($urandom);
      cyc();
    end
    fetch = 0;
    ld_valid = 1;
    ld_data = b;
    cyc();
    ld_valid = 0;
    ld_data = 8'($urandom);
  endtask
  task automatic load_word(logic [31:0] x);
    for (int k = 0; k < NBT; k++) beat(x[k*LW +: LW]);
`ifdef CTRL_PROG_PARITY_EN
    beat({7'($urandom), ^x[IW-1:0]});
`endif
  endtask
`ifdef CTRL_PROG_PARITY_EN
  task automatic load_bad(logic [31:0] x);
    for (int k = 0; k < NBT; k++) beat(x[k*LW +: LW]);
    beat({7'($urandom), ~^x[IW-1:0]});
  endtask
`endif
  task automatic rand_fetch(int n);
    repeat (n) begin
      fetch = 1'($urandom);
      pc = 5'($urandom_range(0, 8));
      cyc();
    end
    fetch = 0;
  endtask
  initial begin
    rst = 1;
    cyc();
    chk = 1;
    cyc();
    check("rst prog_len", 64'(prog_len), 0);
    check("rst running", 64'(running), 0);
    check("rst ld_ready", 64'(ld_ready), 0);
    check("rst instr_word", 64'(instr_word), 0);
    rst = 0;
    prog = 1;
    cyc();
    load_word(32'h12345678);
    load_word(32'h0badcafe);
    load_word(32'hffffffff);
    load_word(32'h00c0ffee);
    prog = 0;
    cyc();
    check("len4", 64'(prog_len), 4);
    check("run4", 64'(running), 1);
    check("err4", 64'(load_err), 0);
    fetch = 1;
    pc = 2;
    cyc();
    check("pc2 word", 64'(instr_word), 64'h7fffffff);
    check("pc2 valid", 64'(instr_valid), 1);
    pc = 0;
    cyc();
    check("pc0 word", 64'(instr_word), 64'h12345678);
    pc = 1;
    cyc();
    check("pc1 word", 64'(instr_word), 64'h0badcafe);
    pc = 2;
    cyc();
    pc = 3;
    cyc();
    check("pc3 word", 64'(instr_word), 64'h00c0ffee);
    pc = 7;
    cyc();
    check("oob word", 64'(instr_word), 0);
    check("oob flag", 64'(pc_oob), 1);
    fetch = 0;
    repeat (3) cyc();
    check("oob sticky", 64'(pc_oob), 1);
    check("valid drop", 64'(instr_valid), 0);
    rand_fetch(40);
    prog = 1;
    fetch = 1;
    pc = 0;
    cyc();
    fetch = 0;
    check("oob clear", 64'(pc_oob), 0);
    check("prog prio", 64'(instr_valid), 0);
    load_word($urandom);
    load_word($urandom);
    beat(8'($urandom));
    beat(8'($urandom));
    prog = 0;
    cyc();
    check("partial len", 64'(prog_len), 2);
    check("partial err", 64'(load_err), 1);
    rand_fetch(20);
    prog = 1;
    cyc();
    load_word(32'h2aaa5555);
    repeat (SIZE - 1) load_word($urandom);
    check("full ready", 64'(ld_ready), 0);
    load_word($urandom);
    prog = 0;
    cyc();
    check("full len", 64'(prog_len), 32);
    fetch = 1;
    pc = 0;
    cyc();
    fetch = 0;
    check("mem0 kept", 64'(instr_word), 64'h2aaa5555);
`ifdef CTRL_PROG_PARITY_EN
    prog = 1;
    cyc();
    load_word($urandom);
    load_bad($urandom);
    prog = 0;
    cyc();
    check("parity len", 64'(prog_len), 1);
    check("parity err", 64'(load_err), 1);
`endif
    prog = 1;
    cyc();
    beat(8'($urandom));
    beat(8'($urandom));
    beat(8'($urandom));
    rst = 1;
    cyc();
    check("mid rst len", 64'(prog_len), 0);
    check("mid rst running", 64'(running), 0);
    check("mid rst ready", 64'(ld_ready), 0);
    check("mid rst err", 64'(load_err), 0);
    rst = 0;
    cyc();
    load_word($urandom);
    prog = 0;
    cyc();
    check("fresh len", 64'(prog_len), 1);
    repeat (25) begin
      prog = 1;
      cyc();
      repeat ($urandom_range(0, 5)) begin
`ifdef CTRL_PROG_PARITY_EN
        if ($urandom_range(3) == 0) load_bad($urandom);
        else load_word($urandom);
`else
        load_word($urandom);
`endif
      end
      if ($urandom_range(1) == 1) repeat ($urandom_range(1, NBT - 1)) beat(8'($urandom));
      prog = 0;
      cyc();
      rand_fetch(30);
    end
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
